word_serializer: RTL and testbench

Parallel-in, serial-out word serializer for the universal shift register family. Accepts one frame of SIZE words of WIDTH bits in a single valid/ready transfer and emits the words one per transfer on a valid/ready output stream, oldest word (index 0) first. It performs the reverse of the variable-depth shift register: that block accumulates a stream of words in SIZE stages, and this block unloads a stored frame as a stream. Used wherever a stored frame must be replayed word by word into a register chain.

---
 rtl/word_serializer_pkg.sv | 22 ++
 rtl/word_select_mux.sv | 28 ++
 rtl/word_serializer.sv | 129 ++++++++++++
 tb/tb_word_serializer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/word_serializer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : word_serializer_pkg                                          |
// | Description : Shared types and helpers for the shift register family.      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package word_serializer_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Width of an index counter for n entries, never narrower than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : word_serializer_pkg
`default_nettype wire

// File: rtl/word_select_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : word_select_mux                                              |
// | Description : Selects one WIDTH-bit word of a SIZE-word frame by index.    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module word_select_mux #(
  parameter int WIDTH = 4,
  parameter int SIZE  = 3,
  parameter int SEL_W = 2
) (
  input  logic [WIDTH*SIZE-1:0] frame,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      word
);

  // Out-of-range indices yield zero; the caller never consumes them.
  always_comb begin
    word = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (sel == SEL_W'(i)) begin
        word = frame[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule : word_select_mux
`default_nettype wire

// File: rtl/word_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : word_serializer                                              |
// | Description : Parallel-in, serial-out frame serializer, valid/ready I/O.   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int SIZE  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [WIDTH*SIZE-1:0] load_data,
  input  logic                  load_valid,
  output logic                  load_ready,
  output logic [WIDTH-1:0]      dout,
  output logic                  dout_valid,
  output logic                  dout_last,
  input  logic                  dout_ready
);

  localparam int CW = cnt_width(SIZE);
  localparam logic [CW-1:0] c_last_idx = CW'(SIZE - 1);

  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic [WIDTH*SIZE-1:0] r_frame, w_frame_nxt;
  logic [WIDTH-1:0]      r_dout, w_dout_nxt;
  logic                  r_valid, w_valid_nxt;
  logic                  r_last, w_last_nxt;

  logic                  w_at_last;
  logic                  w_load_xfer;
  logic                  w_out_xfer;
  logic [CW-1:0]         w_cnt_inc;
  logic [CW:0]           w_sel;
  logic [WIDTH-1:0]      w_next_word;

  assign w_at_last   = (r_cnt == c_last_idx);
  assign load_ready  = ce && ((r_state == IDLE) ||
                              ((r_state == SHIFT) && w_at_last && dout_ready));
  assign w_load_xfer = ce && load_valid && load_ready;
  assign w_out_xfer  = ce && r_valid && dout_ready;
  assign w_cnt_inc   = r_cnt + 1'b1;
  // One extra bit so the index past the last word cannot alias word 0.
  assign w_sel       = {1'b0, r_cnt} + 1'b1;

  word_select_mux #(
    .WIDTH (WIDTH),
    .SIZE  (SIZE),
    .SEL_W (CW + 1)
  ) u_word_select_mux (
    .frame (r_frame),
    .sel   (w_sel),
    .word  (w_next_word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_frame <= '0;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_frame <= w_frame_nxt;
      r_dout  <= w_dout_nxt;
      r_valid <= w_valid_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_frame_nxt = r_frame;
    w_dout_nxt  = r_dout;
    w_valid_nxt = r_valid;
    w_last_nxt  = r_last;

    case (r_state)
      IDLE: begin
        if (w_load_xfer) begin
          w_state_nxt = SHIFT;
          w_cnt_nxt   = '0;
          w_frame_nxt = load_data;
          w_dout_nxt  = load_data[WIDTH-1:0];
          w_valid_nxt = 1'b1;
          w_last_nxt  = (SIZE == 1);
        end
      end
      SHIFT: begin
        if (w_out_xfer) begin
          if (!w_at_last) begin
            w_cnt_nxt  = w_cnt_inc;
            w_dout_nxt = w_next_word;
            w_last_nxt = (w_cnt_inc == c_last_idx);
          end else if (w_load_xfer) begin
            // Back-to-back reload: first word of the new frame follows with no bubble.
            w_cnt_nxt   = '0;
            w_frame_nxt = load_data;
            w_dout_nxt  = load_data[WIDTH-1:0];
            w_last_nxt  = (SIZE == 1);
          end else begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign dout_last  = r_last;

endmodule : word_serializer
`default_nettype wire

// File: tb/tb_word_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_word_serializer                                           |
// | Description : Scoreboard bench for word_serializer (SIZE 3 and SIZE 1).    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_word_serializer;

  logic        clk;
  logic        rst;
  logic        ce;

  logic [11:0] load_data;
  logic        load_valid;
  logic        load_ready;
  logic [3:0]  dout;
  logic        dout_valid;
  logic        dout_last;
  logic        dout_ready;

  logic [3:0]  s1_load_data;
  logic        s1_load_valid;
  logic        s1_load_ready;
  logic [3:0]  s1_dout;
  logic        s1_dout_valid;
  logic        s1_dout_last;
  logic        s1_dout_ready;

  int n_checks = 0;
  int n_pass   = 0;

  logic [4:0] q0[$];
  logic [4:0] q1[$];

  word_serializer #(.WIDTH(4), .SIZE(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_last  (dout_last),
    .dout_ready (dout_ready)
  );

  word_serializer #(.WIDTH(4), .SIZE(1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .load_data  (s1_load_data),
    .load_valid (s1_load_valid),
    .load_ready (s1_load_ready),
    .dout       (s1_dout),
    .dout_valid (s1_dout_valid),
    .dout_last  (s1_dout_last),
    .dout_ready (s1_dout_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Output monitors: a transfer is seen at the negedge before the edge that commits it.
  always @(negedge clk) begin
    if (ce && dout_valid && dout_ready) begin
      if (q0.size() == 0) check_eq("s3_unexpected_word", {28'd0, dout}, 32'hffff_ffff);
      else begin
        logic [4:0] e;
        e = q0.pop_front();
        check_eq("s3_dout", {28'd0, dout}, {28'd0, e[3:0]});
        check_eq("s3_dout_last", {31'd0, dout_last}, {31'd0, e[4]});
      end
    end
    if (ce && s1_dout_valid && s1_dout_ready) begin
      if (q1.size() == 0) check_eq("s1_unexpected_word", {28'd0, s1_dout}, 32'hffff_ffff);
      else begin
        logic [4:0] e;
        e = q1.pop_front();
        check_eq("s1_dout", {28'd0, s1_dout}, {28'd0, e[3:0]});
        check_eq("s1_dout_last", {31'd0, s1_dout_last}, {31'd0, e[4]});
      end
    end
  end

  task automatic push_frame(input logic [11:0] data);
    for (int i = 0; i < 3; i++) q0.push_back({(i == 2), data[i*4 +: 4]});
  endtask

  // Offers a frame, returns 1 ns after the edge that accepts it.
  task automatic send_frame(input logic [11:0] data);
    bit done;
    done = 0;
    push_frame(data);
    load_data  = data;
    load_valid = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (load_ready && ce) done = 1;
      @(posedge clk); #1;
    end
    if (!done) check_eq("load_timeout", 0, 1);
    load_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 30 && q0.size() != 0; k++) @(posedge clk);
    #1;
    check_eq("drain", q0.size(), 0);
  endtask

  initial begin
    rst = 1'b0; ce = 1'b0;
    load_data = '0; load_valid = 1'b0; dout_ready = 1'b0;
    s1_load_data = '0; s1_load_valid = 1'b0; s1_dout_ready = 1'b0;

    // Reset state
    #100;
    check_eq("rst_dout", {28'd0, dout}, 0);
    check_eq("rst_valid", {31'd0, dout_valid}, 0);
    check_eq("rst_last", {31'd0, dout_last}, 0);
    check_eq("rst_load_ready_ce0", {31'd0, load_ready}, 0);
    ce = 1'b1; #1;
    check_eq("rst_load_ready_ce1", {31'd0, load_ready}, 1);
    @(posedge clk); #1; rst = 1'b1;

    // Basic frame
    dout_ready = 1'b1;
    send_frame(12'hcba);
    wait_drain();
    check_eq("basic_idle_valid", {31'd0, dout_valid}, 0);
    check_eq("basic_idle_ready", {31'd0, load_ready}, 1);

    // Back-to-back frames
    push_frame(12'hcba);
    push_frame(12'hfed);
    load_data = 12'hcba; load_valid = 1'b1;
    @(negedge clk);
    check_eq("b2b_ready_idle", {31'd0, load_ready}, 1);
    @(posedge clk); #1;
    load_data = 12'hfed;
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check_eq("b2b_valid", {31'd0, dout_valid}, 1);
        check_eq("b2b_load_ready", {31'd0, load_ready}, {31'd0, (k == 2)});
        @(posedge clk); #1;
        if (f == 0 && k == 2) load_valid = 1'b0;
      end
    end
    wait_drain();
    check_eq("b2b_idle_valid", {31'd0, dout_valid}, 0);

    // Stall with dout_ready low while b is shown
    send_frame(12'hcba);
    @(posedge clk); #1;
    dout_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check_eq("stall_rdy_dout", {28'd0, dout}, 32'hb);
      check_eq("stall_rdy_valid", {31'd0, dout_valid}, 1);
      check_eq("stall_rdy_last", {31'd0, dout_last}, 0);
    end
    dout_ready = 1'b1;
    wait_drain();

    // Stall with ce low while b is shown
    send_frame(12'hcba);
    @(posedge clk); #1;
    ce = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check_eq("stall_ce_dout", {28'd0, dout}, 32'hb);
      check_eq("stall_ce_valid", {31'd0, dout_valid}, 1);
      check_eq("stall_ce_last", {31'd0, dout_last}, 0);
      check_eq("stall_ce_load_ready", {31'd0, load_ready}, 0);
    end
    ce = 1'b1;
    wait_drain();

    // Asynchronous reset mid-frame
    send_frame(12'hcba);
    @(posedge clk); #2;
    check_eq("pre_rst_dout", {28'd0, dout}, 32'hb);
    rst = 1'b0; #1;
    check_eq("async_rst_dout", {28'd0, dout}, 0);
    check_eq("async_rst_valid", {31'd0, dout_valid}, 0);
    check_eq("async_rst_last", {31'd0, dout_last}, 0);
    q0.delete();
    @(posedge clk); #1; rst = 1'b1; #1;
    check_eq("post_rst_load_ready", {31'd0, load_ready}, 1);
    send_frame(12'h321);
    wait_drain();

    // SIZE = 1 instance
    q1.push_back({1'b1, 4'h7});
    q1.push_back({1'b1, 4'h8});
    s1_dout_ready = 1'b1;
    s1_load_data = 4'h7; s1_load_valid = 1'b1;
    @(negedge clk);
    check_eq("s1_ready_idle", {31'd0, s1_load_ready}, {31'd0, s1_dout_ready});
    @(posedge clk); #1;
    s1_load_data = 4'h8;
    @(negedge clk);
    check_eq("s1_ready_b2b", {31'd0, s1_load_ready}, {31'd0, s1_dout_ready});
    @(posedge clk); #1;
    s1_load_valid = 1'b0;
    s1_dout_ready = 1'b0;
    @(negedge clk);
    check_eq("s1_ready_stall", {31'd0, s1_load_ready}, {31'd0, s1_dout_ready});
    check_eq("s1_stall_dout", {28'd0, s1_dout}, 32'h8);
    @(posedge clk); #1;
    s1_dout_ready = 1'b1;
    @(negedge clk);
    check_eq("s1_ready_release", {31'd0, s1_load_ready}, {31'd0, s1_dout_ready});
    @(posedge clk); #1;
    check_eq("s1_drain", q1.size(), 0);
    check_eq("s1_idle_valid", {31'd0, s1_dout_valid}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_word_serializer
`default_nettype wire
